booth_seq_mul: RTL and testbench

- Sequential signed multiplier built around radix-4 Booth recoding.
- Sits directly downstream of the Booth encoding stage and consumes one Booth digit per cycle.
- Each cycle it forms the selected partial product (0, ±X, ±2X), shifts it into place and accumulates it into the 2W-bit product.
- Accepts and returns operands over valid/ready handshakes and serves as the low-area alternative to the array multiplier.

---
 rtl/booth_pkg.sv | 39 +++
 rtl/booth_pp_gen.sv | 49 ++++
 rtl/booth_seq_mul.sv | 104 ++++++++++
 tb/tb_booth_seq_mul.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and the radix-4 Booth digit classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_P1   = 3'd1,
    D_P2   = 3'd2,
    D_M1   = 3'd3,
    D_M2   = 3'd4
  } digit_t;

  // Window is {y[2i+1], y[2i], y[2i-1]}.
  function automatic digit_t booth_class(input logic [2:0] win);
    digit_t cls;
    case (win)
      3'b001, 3'b010: cls = D_P1;
      3'b011:         cls = D_P2;
      3'b100:         cls = D_M2;
      3'b101, 3'b110: cls = D_M1;
      default:        cls = D_ZERO;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_gen.sv
// ============================================================================
// Module      : booth_pp_gen
// Description : Combinational Booth partial-product selector (0, +-X, +-2X).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]     digit_i,
  input  logic [2*W-1:0] x_i,
  output logic [2*W-1:0] pp_o,
  output logic           neg_o
);

  logic [2*W-1:0] w_x2;
  digit_t         w_cls;

  assign w_x2  = {x_i[2*W-2:0], 1'b0};
  assign w_cls = booth_class(digit_i);

  // Negative digits emit the ones' complement; the +1 rides in on neg_o.
  always_comb begin
    pp_o  = '0;
    neg_o = 1'b0;
    case (w_cls)
      D_P1: pp_o = x_i;
      D_P2: pp_o = w_x2;
      D_M1: begin
        pp_o  = ~x_i;
        neg_o = 1'b1;
      end
      D_M2: begin
        pp_o  = ~w_x2;
        neg_o = 1'b1;
      end
      default: begin
        pp_o  = '0;
        neg_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mul.sv
// ============================================================================
// Module      : booth_seq_mul
// Description : Sequential signed radix-4 Booth multiplier, one digit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x_in,
  input  logic [W-1:0]   y_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W / 2 - 1);

  state_t         state_q, state_d;
  logic [2*W-1:0] x_q, x_d;
  logic [W:0]     yr_q, yr_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [2*W-1:0] w_x_shift;
  logic [2*W-1:0] w_pp;
  logic           w_neg;

  // Shift X before complementing so the carry-in lands at the digit weight.
  assign w_x_shift = x_q << {cnt_q, 1'b0};

  booth_pp_gen #(.W(W)) u_pp_gen (
    .digit_i (yr_q[2:0]),
    .x_i     (w_x_shift),
    .pp_o    (w_pp),
    .neg_o   (w_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      yr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      yr_q    <= yr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    yr_d    = yr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = {{W{x_in[W-1]}}, x_in};
          yr_d    = {y_in, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + w_pp + {{(2*W-1){1'b0}}, w_neg};
        yr_d  = $signed(yr_q) >>> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mul.sv
// ============================================================================
// Module      : tb_booth_seq_mul
// Description : Directed self-checking bench for booth_seq_mul (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_mul;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x_in;
  logic [W-1:0]   y_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks;
  int n_fail;

  booth_seq_mul #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, check latency/result, optionally stall, then release.
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp, input int stall, input bit full);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    x_in     = x;
    y_in     = y;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (full) check("latency", 32'(cyc), 32'd4);
    check("product", 32'(product), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      tick();
      if (full) check("stall_product", 32'(product), 32'(exp));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (full) begin
      check("idle_after_done", 32'(in_ready), 32'd1);
      check("idle_holds_product", 32'(product), 32'(exp));
    end
  endtask

  initial begin
    int cyc;
    logic [15:0] ref_p;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);

    run_mul(8'd3, 8'd5, 16'h000F, 0, 1'b1);
    run_mul(8'h80, 8'h80, 16'h4000, 0, 1'b1);
    run_mul(8'h80, 8'h7F, 16'hC080, 0, 1'b1);
    run_mul(8'h7F, 8'hFF, 16'hFF81, 0, 1'b1);
    run_mul(8'h00, 8'h00, 16'h0000, 0, 1'b1);
    run_mul(8'hFF, 8'hFF, 16'h0001, 1, 1'b1);

    // Backpressure with competing operands presented while busy.
    x_in = 8'hF9;
    y_in = 8'd9;
    in_valid = 1'b1;
    tick();
    x_in = 8'd100;
    y_in = 8'd100;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 6; i++) begin
      check("bp_product", 32'(product), 32'h0000FFC1);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    check("bp_product_end", 32'(product), 32'h0000FFC1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 32'd1);
    tick();
    check("bp_no_ghost_start", 32'(busy), 32'd0);

    // Reset landing on the second CALC cycle.
    x_in = 8'd5;
    y_in = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    run_mul(8'd2, 8'd2, 16'd4, 0, 1'b1);

    // Strided sweep across the signed range with random consumer stalls.
    for (int xi = -128; xi <= 127; xi += 15) begin
      for (int yi = -128; yi <= 127; yi += 15) begin
        ref_p = 16'(xi * yi);
        run_mul(8'(xi), 8'(yi), ref_p, int'($urandom_range(0, 2)), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
